// File: rtl/pool_map_collector.sv
// Ping-pong feature-map collector for the layer-1 pool output stream.
// Raster-order writes fill one bank while the reader consumes the other.
module pool_map_collector #(
  parameter int OP    = 8,
  parameter int MAP_W = 14,
  parameter int MAP_H = 14,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [OP:0]   pool_in,
  input  logic                 valid,
  output logic                 map_ready,
  output logic                 map_bank,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [OP:0]   rd_data,
  input  logic                 map_release,
  output logic [7:0]           frame_cnt,
  output logic                 overflow
);

  localparam int N = MAP_W * MAP_H;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic signed [OP:0] mem [2][N];

  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_addr;
  logic [1:0]    full;

  logic wr_en;
  logic wr_last;
  logic rel;

  // all decisions use pre-edge full[], so a release never rescues a sample
  assign wr_en   = valid && !full[wr_bank];
  assign wr_last = wr_en && (wr_addr == LAST);
  assign rel     = map_release && full[rd_bank];

  assign map_ready = full[rd_bank];
  assign map_bank  = rd_bank;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_bank][wr_addr] <= pool_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      frame_cnt <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      if (valid && full[wr_bank])
        overflow <= 1'b1;
      if (wr_en) begin
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_addr       <= '0;
          frame_cnt     <= frame_cnt + 8'd1;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      // completion and release always hit different banks
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_addr <= LAST)
      rd_data <= mem[rd_bank][rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_pool_map_collector.sv
// Directed bench for pool_map_collector.
// Inputs change 1 ns after posedge; outputs are sampled there too.
module tb_pool_map_collector;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [8:0] pool_in;
  logic              valid;
  logic              map_ready;
  logic              map_bank;
  logic [7:0]        rd_addr;
  logic signed [8:0] rd_data;
  logic              map_release;
  logic [7:0]        frame_cnt;
  logic              overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pool_map_collector dut (
    .clk        (clk),
    .reset      (reset),
    .pool_in    (pool_in),
    .valid      (valid),
    .map_ready  (map_ready),
    .map_bank   (map_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .map_release(map_release),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int trunc9(input int v);
    logic signed [8:0] t;
    t = v[8:0];
    return int'(t);
  endfunction

  function automatic int val(input int mode, input int k);
    case (mode)
      0:       return k;
      1:       return -k;
      2:       return trunc9(1000 - k);
      default: return k + 7;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send(input int v, input int gap, input logic rel);
    valid = 1'b0;
    repeat (gap) step();
    pool_in     = v[8:0];
    valid       = 1'b1;
    map_release = rel;
    step();
    valid       = 1'b0;
    map_release = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int gapmax,
                            input logic rel_last, input int cnt);
    for (int k = 0; k < cnt; k++)
      send(val(mode, k), $urandom_range(gapmax, 0),
           rel_last && (k == 195));
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    rd_addr = a[7:0];
    step();
    check(tag, int'(rd_data), exp);
  endtask

  task automatic release_map();
    map_release = 1'b1;
    step();
    map_release = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    pool_in     = '0;
    valid       = 1'b0;
    rd_addr     = '0;
    map_release = 1'b0;

    // 1: reset state, first frame with gaps
    do_reset();
    check("rst_ready", map_ready, 0);
    check("rst_bank", map_bank, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rdata", int'(rd_data), 0);
    send_frame(0, 2, 1'b0, 195);
    check("t1_not_yet", map_ready, 0);
    send(195, 1, 1'b0);
    check("t1_ready", map_ready, 1);
    check("t1_bank", map_bank, 0);
    check("t1_fcnt", frame_cnt, 1);
    rd("t1_rd0", 0, 0);
    rd("t1_rd5", 5, 5);
    rd("t1_rd100", 100, 100);
    rd("t1_rd195", 195, 195);

    // 2: second frame into bank 1, then release bank 0
    send_frame(1, 0, 1'b0, 196);
    check("t2_fcnt", frame_cnt, 2);
    check("t2_bank", map_bank, 0);
    release_map();
    check("t2_rel_bank", map_bank, 1);
    check("t2_rel_ready", map_ready, 1);
    rd("t2_rd5", 5, -5);

    // 3: third frame dropped, fourth lands in bank 0
    do_reset();
    send_frame(0, 0, 1'b0, 196);
    send_frame(3, 0, 1'b0, 196);
    check("t3_ovf0", overflow, 0);
    send_frame(1, 0, 1'b0, 196);
    check("t3_ovf", overflow, 1);
    check("t3_fcnt", frame_cnt, 2);
    release_map();
    check("t3_bank1", map_bank, 1);
    send_frame(2, 0, 1'b0, 196);
    check("t3_fcnt4", frame_cnt, 3);
    check("t3_ovf_hold", overflow, 1);
    rd("t3_b1_rd3", 3, 10);
    release_map();
    check("t3_bank0", map_bank, 0);
    check("t3_ready0", map_ready, 1);
    rd("t3_b0_rd0", 0, trunc9(1000));
    rd("t3_b0_rd195", 195, trunc9(805));

    // 4: reset mid-frame discards partial map
    do_reset();
    send_frame(0, 0, 1'b0, 100);
    do_reset();
    check("t4_ready_rst", map_ready, 0);
    check("t4_fcnt_rst", frame_cnt, 0);
    send_frame(2, 1, 1'b0, 195);
    check("t4_not_yet", map_ready, 0);
    send(val(2, 195), 0, 1'b0);
    check("t4_ready", map_ready, 1);
    check("t4_bank", map_bank, 0);
    rd("t4_rd0", 0, trunc9(1000));
    rd("t4_rd195", 195, trunc9(805));

    // 5: release on the edge that completes bank 1
    do_reset();
    send_frame(0, 0, 1'b0, 196);
    send_frame(1, 0, 1'b1, 196);
    check("t5_bank", map_bank, 1);
    check("t5_ready", map_ready, 1);
    check("t5_ovf", overflow, 0);
    check("t5_fcnt", frame_cnt, 2);
    rd("t5_rd7", 7, -7);
    release_map();
    check("t5_b0_free", map_ready, 0);
    check("t5_b0_bank", map_bank, 0);

    // 6: extreme values, out-of-range read, ignored release
    do_reset();
    send(-256, 0, 1'b0);
    send(255, 0, 1'b0);
    rd("t6_rd0", 0, -256);
    rd("t6_rd1", 1, 255);
    rd("t6_rd200", 200, 0);
    release_map();
    check("t6_ign_bank", map_bank, 0);
    check("t6_ign_ready", map_ready, 0);
    for (int k = 2; k < 196; k++)
      send(k, 0, 1'b0);
    check("t6_ready", map_ready, 1);
    check("t6_bank", map_bank, 0);
    check("t6_fcnt", frame_cnt, 1);
    rd("t6_rd0_full", 0, -256);
    rd("t6_rd150", 150, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
